// File: rtl/io_pkg.sv
// Shared register offsets and bit positions for the io_responder register window.
package io_pkg;

    typedef enum logic [2:0] {
        OFF_DATA   = 3'd0,
        OFF_STATUS = 3'd1,
        OFF_TLO    = 3'd2,
        OFF_THI    = 3'd3,
        OFF_CTRL   = 3'd4
    } reg_off_e;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_EXPIRED  = 2;
    localparam int ST_OVERFLOW = 3;

    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_CLEAR   = 2;
    localparam int CTRL_IRQ_EXP = 3;
    localparam int CTRL_IRQ_OVF = 4;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with a registered entry count; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module io_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder: 8-byte register window with a TX FIFO and an interval timer.
// Define IO_RESPONDER_IRQ_EN to add the irq output and the CTRL interrupt-enable bits 4:3.
module io_responder
    import io_pkg::*;
#(
    parameter logic [7:0] BASE_PAGE  = 8'hFE,
    parameter int         FIFO_DEPTH = 4,
    parameter int         PRESCALE   = 1
) (
    input  logic        CLK,
    input  logic        R,
    input  logic [15:0] Address,
    input  logic [7:0]  DataIn,
    input  logic        WE,
    output logic [7:0]  DataOut,
    output logic        Hit,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
`ifdef IO_RESPONDER_IRQ_EN
    output logic        irq,
`endif
    output logic        timer_expired
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    reg_off_e       offset;
    logic           wr_data, wr_tlo, wr_thi, wr_ctrl, clear_flags;
    logic           fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           enable, auto_reload, expired, overflow;
    logic [15:0]    count, reload;
    logic [7:0]     lo_latch;
    logic [PW-1:0]  presc;
    logic           tick, tick_eff, expire, overflow_set;
    logic [7:0]     status_rd, ctrl_rd;
`ifdef IO_RESPONDER_IRQ_EN
    logic           irq_exp_en, irq_ovf_en;
`endif

    assign Hit         = (Address[15:8] == BASE_PAGE) && (Address[7:3] == 5'd0);
    assign offset      = reg_off_e'(Address[2:0]);
    assign wr_data     = WE && Hit && (offset == OFF_DATA);
    assign wr_tlo      = WE && Hit && (offset == OFF_TLO);
    assign wr_thi      = WE && Hit && (offset == OFF_THI);
    assign wr_ctrl     = WE && Hit && (offset == OFF_CTRL);
    assign clear_flags = wr_ctrl && DataIn[CTRL_CLEAR];

    assign tx_valid     = !fifo_empty;
    assign fifo_pop     = tx_valid && tx_ready;
    assign overflow_set = wr_data && fifo_full && !fifo_pop;

    io_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (CLK),
        .rst   (R),
        .push  (wr_data),
        .pop   (fifo_pop),
        .din   (DataIn),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A THI write in the same cycle as a tick overrides that tick completely.
    assign tick     = enable && (presc == PW'(PRESCALE - 1));
    assign tick_eff = tick && !wr_thi;
    assign expire   = tick_eff && (count == 16'd0);

    always_ff @(posedge CLK) begin
        if (R) begin
            enable      <= 1'b0;
            auto_reload <= 1'b0;
            expired     <= 1'b0;
            overflow    <= 1'b0;
            count       <= 16'd0;
            reload      <= 16'd0;
            lo_latch    <= 8'd0;
            presc       <= '0;
`ifdef IO_RESPONDER_IRQ_EN
            irq_exp_en  <= 1'b0;
            irq_ovf_en  <= 1'b0;
`endif
        end else begin
            expired  <= expire || (expired && !clear_flags);
            overflow <= overflow_set || (overflow && !clear_flags);

            if (wr_tlo) lo_latch <= DataIn;

            if (wr_thi) begin
                reload <= {DataIn, lo_latch};
                count  <= {DataIn, lo_latch};
            end else if (tick_eff) begin
                if (count != 16'd0)  count <= count - 16'd1;
                else if (auto_reload) count <= reload;
            end

            if (wr_thi || !enable || tick) presc <= '0;
            else                           presc <= presc + 1'b1;

            if (wr_ctrl) begin
                enable      <= DataIn[CTRL_ENABLE];
                auto_reload <= DataIn[CTRL_AUTO];
`ifdef IO_RESPONDER_IRQ_EN
                irq_exp_en  <= DataIn[CTRL_IRQ_EXP];
                irq_ovf_en  <= DataIn[CTRL_IRQ_OVF];
`endif
            end else if (expire && !auto_reload) begin
                enable <= 1'b0;
            end
        end
    end

    assign timer_expired = expired;
`ifdef IO_RESPONDER_IRQ_EN
    assign irq = (expired && irq_exp_en) || (overflow && irq_ovf_en);
`endif

    always_comb begin
        status_rd              = 8'h00;
        status_rd[ST_EMPTY]    = fifo_empty;
        status_rd[ST_FULL]     = fifo_full;
        status_rd[ST_EXPIRED]  = expired;
        status_rd[ST_OVERFLOW] = overflow;
        ctrl_rd                = 8'h00;
        ctrl_rd[CTRL_ENABLE]   = enable;
        ctrl_rd[CTRL_AUTO]     = auto_reload;
`ifdef IO_RESPONDER_IRQ_EN
        ctrl_rd[CTRL_IRQ_EXP]  = irq_exp_en;
        ctrl_rd[CTRL_IRQ_OVF]  = irq_ovf_en;
`endif
        DataOut = 8'h00;
        if (Hit) begin
            case (offset)
                OFF_DATA:   DataOut = 8'(fifo_count);
                OFF_STATUS: DataOut = status_rd;
                OFF_TLO:    DataOut = count[7:0];
                OFF_THI:    DataOut = count[15:8];
                OFF_CTRL:   DataOut = ctrl_rd;
                default:    DataOut = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: directed scenarios plus randomized bus traffic
// checked against a queue-based behavioural model.
module tb_io_responder;

    localparam logic [7:0] BASE_PAGE  = 8'hFE;
    localparam int         FIFO_DEPTH = 4;
    localparam int         PRESCALE   = 1;

    logic        CLK = 1'b0;
    logic        R;
    logic [15:0] Address;
    logic [7:0]  DataIn;
    logic        WE;
    logic [7:0]  DataOut;
    logic        Hit;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_expired;
`ifdef IO_RESPONDER_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0] mQ[$];
    bit         mOvf, mExp, mEn, mAuto, mIrqExp, mIrqOvf;
    int         mCnt, mRel, mPresc;
    logic [7:0] mLo;

    io_responder #(.BASE_PAGE(BASE_PAGE), .FIFO_DEPTH(FIFO_DEPTH), .PRESCALE(PRESCALE)) dut (
        .CLK           (CLK),
        .R             (R),
        .Address       (Address),
        .DataIn        (DataIn),
        .WE            (WE),
        .DataOut       (DataOut),
        .Hit           (Hit),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
`ifdef IO_RESPONDER_IRQ_EN
        .irq           (irq),
`endif
        .timer_expired (timer_expired)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit modelHit(input logic [15:0] a);
        return (a[15:8] == BASE_PAGE) && (a[7:3] == 5'd0);
    endfunction

    function automatic logic [7:0] modelRead(input logic [15:0] a);
        if (!modelHit(a)) return 8'h00;
        case (a[2:0])
            3'd0: return 8'(mQ.size());
            3'd1: return {4'h0, mOvf, mExp, mQ.size() == FIFO_DEPTH, mQ.size() == 0};
            3'd2: return 8'(mCnt & 255);
            3'd3: return 8'((mCnt >> 8) & 255);
`ifdef IO_RESPONDER_IRQ_EN
            3'd4: return {3'b000, mIrqOvf, mIrqExp, 1'b0, mAuto, mEn};
`else
            3'd4: return {6'b000000, mAuto, mEn};
`endif
            default: return 8'h00;
        endcase
    endfunction

    task automatic modelStep(input logic rst, input logic we, input logic [15:0] a,
                             input logic [7:0] d, input logic ready);
        bit wr, thiW, ctrlW, clr, tick, newExp, popped, ovfSet, oldEn, oldAuto;
        int oldSize;
        if (rst) begin
            mQ.delete();
            mOvf = 0; mExp = 0; mEn = 0; mAuto = 0; mIrqExp = 0; mIrqOvf = 0;
            mCnt = 0; mRel = 0; mPresc = 0; mLo = 8'h00;
            return;
        end
        wr      = we && modelHit(a);
        thiW    = wr && (a[2:0] == 3'd3);
        ctrlW   = wr && (a[2:0] == 3'd4);
        clr     = ctrlW && d[2];
        tick    = mEn && (mPresc == PRESCALE - 1) && !thiW;
        newExp  = tick && (mCnt == 0);
        oldEn   = mEn;
        oldAuto = mAuto;
        oldSize = mQ.size();
        popped  = (oldSize > 0) && ready;
        ovfSet  = 0;
        if (popped) void'(mQ.pop_front());
        if (wr && a[2:0] == 3'd0) begin
            if (oldSize < FIFO_DEPTH || popped) mQ.push_back(d);
            else ovfSet = 1;
        end
        mExp = newExp || (mExp && !clr);
        mOvf = ovfSet || (mOvf && !clr);
        if (thiW) begin
            mRel = int'({d, mLo});
            mCnt = mRel;
        end else if (tick) begin
            if (mCnt == 0) begin
                if (oldAuto) mCnt = mRel;
            end else begin
                mCnt = mCnt - 1;
            end
        end
        if (thiW || !oldEn || tick) mPresc = 0;
        else mPresc = mPresc + 1;
        if (ctrlW) begin
            mEn = d[0]; mAuto = d[1]; mIrqExp = d[3]; mIrqOvf = d[4];
        end else if (newExp && !oldAuto) begin
            mEn = 0;
        end
        if (wr && a[2:0] == 3'd2) mLo = d;
    endtask

    // Drive one bus cycle, check all outputs against the model, then advance one clock.
    task automatic applyStimulus(input logic rst, input logic we, input logic [15:0] a,
                                 input logic [7:0] d, input logic ready);
        R = rst; WE = we; Address = a; DataIn = d; tx_ready = ready;
        #1;
        checkOutput("hit", Hit, modelHit(a));
        checkOutput("dataout", DataOut, modelRead(a));
        checkOutput("tx_valid", tx_valid, mQ.size() != 0);
        checkOutput("tx_data", tx_data, (mQ.size() != 0) ? mQ[0] : 8'h00);
        checkOutput("timer_expired", timer_expired, mExp);
`ifdef IO_RESPONDER_IRQ_EN
        checkOutput("irq", irq, (mExp && mIrqExp) || (mOvf && mIrqOvf));
`endif
        modelStep(rst, we, a, d, ready);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Read a register against a fixed expected value; consumes one idle cycle.
    task automatic peek(input logic [15:0] a, input logic [7:0] exp, input string tag,
                        input logic ready);
        R = 1'b0; WE = 1'b0; Address = a; DataIn = 8'h00; tx_ready = ready;
        #1;
        checkOutput(tag, DataOut, exp);
        modelStep(1'b0, 1'b0, a, 8'h00, ready);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic [7:0] tail [4];
        R = 1'b1; WE = 1'b0; Address = 16'h0000; DataIn = 8'h00; tx_ready = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        modelStep(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);

        // Reset state and decode miss
        checkOutput("rst_tx_valid", tx_valid, 1'b0);
        peek(16'hFE01, 8'h01, "rst_status", 1'b0);
        R = 1'b0; WE = 1'b0; Address = 16'h1234;
        #1;
        checkOutput("miss_hit", Hit, 1'b0);
        peek(16'h1234, 8'h00, "miss_data", 1'b0);

        // Overfill with the sink stalled, then drain
        for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b1, 16'hFE00, 8'(8'h11 * i), 1'b0);
        peek(16'hFE01, 8'h0A, "ovf_status", 1'b0);
        peek(16'hFE00, 8'h04, "ovf_count", 1'b0);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("drain_data", tx_data, 16'(8'h11 * i));
            applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        end
        checkOutput("drain_empty", tx_valid, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE04, 8'h04, 1'b0);
        peek(16'hFE01, 8'h01, "clr_status", 1'b0);

        // Push and pop together while full
        applyStimulus(1'b0, 1'b1, 16'hFE00, 8'hAA, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE00, 8'hBB, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE00, 8'hCC, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE00, 8'hDD, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE00, 8'hEE, 1'b1);
        peek(16'hFE01, 8'h02, "pushpop_status", 1'b0);
        peek(16'hFE00, 8'h04, "pushpop_count", 1'b0);
        tail[0] = 8'hBB; tail[1] = 8'hCC; tail[2] = 8'hDD; tail[3] = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            checkOutput("pushpop_order", tx_data, tail[i]);
            applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        end
        checkOutput("pushpop_empty", tx_valid, 1'b0);

        // Auto-reload timer with reload 3: expiry 4 cycles after enable
        applyStimulus(1'b0, 1'b1, 16'hFE02, 8'h03, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE03, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE04, 8'h03, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
            checkOutput("tmr_rise", timer_expired, k == 4);
        end
        applyStimulus(1'b0, 1'b1, 16'hFE04, 8'h07, 1'b0);
        checkOutput("tmr_clear", timer_expired, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
            checkOutput("tmr_period", timer_expired, k == 3);
        end

        // One-shot with reload 2
        applyStimulus(1'b0, 1'b1, 16'hFE04, 8'h04, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE02, 8'h02, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE03, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE04, 8'h01, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
            checkOutput("oneshot_rise", timer_expired, k == 3);
        end
        peek(16'hFE04, 8'h00, "oneshot_ctrl", 1'b0);
        peek(16'hFE02, 8'h00, "oneshot_tlo", 1'b0);
        peek(16'hFE03, 8'h00, "oneshot_thi", 1'b0);

        // Reset with FIFO contents and a running timer
        applyStimulus(1'b0, 1'b1, 16'hFE00, 8'h01, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE00, 8'h02, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE00, 8'h03, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE02, 8'h10, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE03, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hFE04, 8'h03, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
        checkOutput("rst2_tx_valid", tx_valid, 1'b0);
        peek(16'hFE01, 8'h01, "rst2_status", 1'b0);
        peek(16'hFE02, 8'h00, "rst2_tlo", 1'b0);
        peek(16'hFE03, 8'h00, "rst2_thi", 1'b0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [15:0] a;
            logic [7:0]  d;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = {BASE_PAGE, 5'b00000, 3'($urandom_range(0, 7))};
            else if (sel == 8) a = {BASE_PAGE, 8'($urandom_range(8, 255))};
            else               a = 16'($urandom);
            case (a[2:0])
                3'd2:    d = 8'($urandom_range(0, 7));
                3'd3:    d = 8'($urandom_range(0, 1));
                default: d = 8'($urandom);
            endcase
            applyStimulus($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), a, d,
                          $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
